frame_stream_buffer: RTL
========================

# frame_stream_buffer

Overlapping-frame buffer for the MFCC front end. It sits between the pre-emphasis FIFO and the Hamming/FFT stages. It collects FRAME_SIZE samples into a circular store, then streams each frame oldest-first on a valid/ready port, zero-padded to PAD_SIZE (the FFT length). After each frame it advances by a run-time hop, either on command or automatically. It generalises the fixed-hop, random-access window buffer with four additions: run-time hop, zero-padding, a streaming handshake with backpressure, and an auto-advance mode.

## Interface
Parameters:
- WIDTH, 16: sample width, two's complement.
- FRAME_SIZE, 400: samples per frame; circular store depth.
- PAD_SIZE, 512: beats emitted per frame; must be ≥ FRAME_SIZE.
- HOP_W, 9: width of hop_i; 2^HOP_W must be > FRAME_SIZE.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- hop_i  in  HOP_W  hop size, sampled on entry to MOVE.
- auto_mode_i  in  1  1 = advance automatically after each frame.
- start_move_i  in  1  one-cycle advance request in manual mode.
- fifo_rd_en_o  out  1  read strobe to the upstream FIFO.
- fifo_data_i  in  WIDTH  FIFO data; valid one cycle after fifo_rd_en_o.
- fifo_empty_i  in  1  upstream FIFO empty.
- out_data_o  out  WIDTH  frame sample, or zero during the pad region.
- out_valid_o  out  1  out_data_o is valid.
- out_ready_i  in  1  downstream accepts the beat.
- out_last_o  out  1  marks beat PAD_SIZE-1 of a frame.
- frame_start_o  out  1  one-cycle pulse on entry to STREAM.
- frame_cnt_o  out  16  number of frames fully streamed; wraps.
- idle_o  out  1  high in DONE (frame emitted, waiting for an advance).

## Operation
- Store: FRAME_SIZE × WIDTH circular array with a single base pointer `base` (0..FRAME_SIZE-1). The oldest sample lives at `base`. Writes during fill start at `base - need` mod FRAME_SIZE, which is the slot freed by the previous advance.
- States: FILL, STREAM, DONE, MOVE. Reset enters FILL with `base`=0 and `need`=FRAME_SIZE.
- FILL
  - fifo_rd_en_o = !fifo_empty_i && issued < need.
  - Each returned sample is written on the cycle after its strobe, and the write index wraps modulo FRAME_SIZE.
  - When `need` samples have been written, go to STREAM.
  - An empty FIFO stalls the fill without losing data.
- STREAM
  - Emit PAD_SIZE beats. Beat k < FRAME_SIZE carries store[(base+k) mod FRAME_SIZE]. Beat k ≥ FRAME_SIZE carries 0.
  - A beat advances only on out_valid_o && out_ready_i.
  - After the last handshake, increment frame_cnt_o and go to DONE.
- DONE
  - idle_o = 1.
  - In manual mode, start_move_i moves to MOVE.
  - In auto mode, move to MOVE on the next cycle and ignore start_move_i.
- MOVE (one cycle)
  - Latch h = hop_i. If hop_i is 0 or greater than FRAME_SIZE, use h = FRAME_SIZE.
  - base ← (base+h) mod FRAME_SIZE; need ← h; go to FILL.
- start_move_i is ignored outside DONE.
- The store is not cleared on reset, but it is never read before a full fill.

## Timing
- Reset values:
  - fifo_rd_en_o=0, out_valid_o=0, out_last_o=0, out_data_o=0.
  - frame_start_o=0, frame_cnt_o=0, idle_o=0.
  - state=FILL, base=0.
- Fill latency: N samples from a non-empty FIFO take N+1 cycles, because strobes are back-to-back and the last write lands one cycle after the last strobe.
- frame_start_o pulses in the first STREAM cycle. out_valid_o first rises the next cycle, since out_data_o is registered.
- Backpressure: while out_valid_o && !out_ready_i, out_data_o, out_last_o and out_valid_o hold stable. With out_ready_i tied high, one beat is emitted per cycle.
- out_last_o rises only together with out_valid_o on beat PAD_SIZE-1.
- idle_o rises the cycle after the last handshake.
- The first strobe of the next fill occurs in the cycle after MOVE.
- Reset asserted mid-fill or mid-stream clears outputs immediately. The partial frame is discarded and the block restarts a full FRAME_SIZE fill. The upstream FIFO is not reset by this block.

## Test plan
- Ramp FIFO (values 0..1599), manual mode, out_ready_i=1:
  - Full fill takes 401 cycles.
  - Stream is 0..399, then 112 zeros; out_last_o on beat 511.
  - frame_cnt_o=1; idle_o=1; base=0.
- Three manual moves with hop_i=160:
  - base progresses 160, 320, 80.
  - Frames begin with samples 160, 320 and 480 respectively.
  - Each fill reads exactly 160 words.
- Random out_ready_i toggling: every stalled beat holds its data, and the emitted sequence is identical to the out_ready_i=1 run.
- fifo_empty_i forced high for 50 cycles mid-fill: no strobes while empty, the fill resumes afterwards, and the frame contents are correct.
- auto_mode_i=1 with hop_i=0, then hop_i=500:
  - Both are treated as hop 400.
  - Frames are consecutive non-overlapping blocks.
  - start_move_i pulses have no effect.
- rst_n low at beat 200 of frame 2: all outputs go to reset values at once, frame_cnt_o=0, and the next frame starts from the next 400 FIFO words.

Source files
------------

// File: rtl/frame_stream_buffer_if.sv
// FIFO read side plus valid/ready frame stream of frame_stream_buffer.
// The master modport is the buffer's own view; slave is the surrounding logic.
interface frame_stream_buffer_if #(
  parameter int WIDTH = 16
);
  logic             fifo_rd_en_o;
  logic [WIDTH-1:0] fifo_data_i;
  logic             fifo_empty_i;
  logic [WIDTH-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             out_last_o;

  modport master (
    output fifo_rd_en_o, out_data_o, out_valid_o, out_last_o,
    input  fifo_data_i, fifo_empty_i, out_ready_i
  );

  modport slave (
    input  fifo_rd_en_o, out_data_o, out_valid_o, out_last_o,
    output fifo_data_i, fifo_empty_i, out_ready_i
  );
endinterface

// File: rtl/frame_stream_buffer.sv
// Overlapping-frame buffer: fills a circular store from the FIFO, streams each
// frame oldest-first zero-padded to PAD_SIZE beats, then advances by a run-time hop.
module frame_stream_buffer #(
  parameter int WIDTH      = 16,
  parameter int FRAME_SIZE = 400,
  parameter int PAD_SIZE   = 512,
  parameter int HOP_W      = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [HOP_W-1:0]      hop_i,
  input  logic                  auto_mode_i,
  input  logic                  start_move_i,
  frame_stream_buffer_if.master bus,
  output logic                  frame_start_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  idle_o
);
  localparam int IW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int CW = $clog2(FRAME_SIZE + 1);
  localparam int BW = $clog2(PAD_SIZE + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_SIZE - 1);
  localparam logic [CW-1:0] FRAME_C  = CW'(FRAME_SIZE);
  localparam logic [CW:0]   FRAME_S  = (CW+1)'(FRAME_SIZE);
  localparam logic [BW-1:0] PAD_B    = BW'(PAD_SIZE);
  localparam logic [BW-1:0] FRAME_B  = BW'(FRAME_SIZE);
  localparam logic [BW-1:0] LAST_B   = BW'(PAD_SIZE - 1);

  typedef enum logic [1:0] {FILL, STREAM, DONE, MOVE} state_t;

  logic [WIDTH-1:0] store [FRAME_SIZE];

  state_t           state_q, state_d;
  logic [IW-1:0]    base_q, base_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [CW-1:0]    need_q, need_d, issued_q, issued_d, written_q, written_d;
  logic             wr_pend_q, wr_pend_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             rd_en, load, accept;
  logic [CW-1:0]    hop_eff;
  logic [CW:0]      base_sum;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    need_d        = need_q;
    issued_d      = issued_q;
    written_d     = written_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    wr_pend_d     = 1'b0;
    beat_d        = beat_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    rd_en         = 1'b0;
    load          = 1'b0;
    accept        = out_valid_q && bus.out_ready_i;
    hop_eff       = (hop_i == '0 || 32'(hop_i) > FRAME_SIZE) ? FRAME_C : CW'(hop_i);
    base_sum      = (CW+1)'(base_q) + (CW+1)'(hop_eff);

    case (state_q)
      FILL: begin
        // Gating on rst_n keeps the strobe low while reset is held.
        rd_en     = rst_n && !bus.fifo_empty_i && (issued_q < need_q);
        wr_pend_d = rd_en;
        issued_d  = issued_q + CW'(rd_en);
        rd_idx_d  = base_q;
        beat_d    = '0;
        if (wr_pend_q) begin
          wr_idx_d  = wrap_inc(wr_idx_q);
          written_d = written_q + 1'b1;
          if (written_q == need_q - 1'b1) begin
            state_d       = STREAM;
            frame_start_d = 1'b1;
          end
        end
      end
      STREAM: begin
        load = (beat_q != PAD_B) && (!out_valid_q || bus.out_ready_i);
        if (accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = (beat_q < FRAME_B) ? store[rd_idx_q] : '0;
          out_last_d  = (beat_q == LAST_B);
          beat_d      = beat_q + 1'b1;
          rd_idx_d    = wrap_inc(rd_idx_q);
        end
        if (accept && out_last_q) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (auto_mode_i || start_move_i) state_d = MOVE;
      end
      MOVE: begin
        base_d    = IW'((base_sum >= FRAME_S) ? base_sum - FRAME_S : base_sum);
        need_d    = hop_eff;
        issued_d  = '0;
        written_d = '0;
        // The slots freed by this advance start exactly at the old base.
        wr_idx_d  = base_q;
        state_d   = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      base_q        <= '0;
      need_q        <= FRAME_C;
      issued_q      <= '0;
      written_q     <= '0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      wr_pend_q     <= 1'b0;
      beat_q        <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      need_q        <= need_d;
      issued_q      <= issued_d;
      written_q     <= written_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      wr_pend_q     <= wr_pend_d;
      beat_q        <= beat_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_pend_q) store[wr_idx_q] <= bus.fifo_data_i;
  end

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.out_data_o   = out_data_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_last_o   = out_last_q;
  assign frame_start_o    = frame_start_q;
  assign frame_cnt_o      = frame_cnt_q;
  assign idle_o           = (state_q == DONE);
endmodule
